// File: rtl/cv_ctrl_ports.sv
`default_nettype none
// ============================================================================
//  Module : cv_ctrl_ports
//  ColecoVision controller-port engine: keypad/joystick words to active-low
//  port lines, key-hold stretcher, optional Super Action spinner quadrature
//  (enabled by defining CV_SPINNER_EN).
//  Rev 1.0 - initial release
// ============================================================================
module cv_ctrl_ports #(
    parameter int NUM_PORTS = 2,
    parameter int KEY_HOLD  = 16,
    parameter int SPIN_DIV  = 64,
    parameter int SPIN_W    = 10
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    ce_i,
    input  logic [20*NUM_PORTS-1:0] joy_i,
    input  logic [NUM_PORTS-1:0]    sel_key_n_i,
    input  logic [NUM_PORTS-1:0]    sel_joy_n_i,
    input  logic [8*NUM_PORTS-1:0]  spin_delta_i,
    input  logic [NUM_PORTS-1:0]    spin_stb_i,
    output logic [4*NUM_PORTS-1:0]  ctrl_dir_o,
    output logic [NUM_PORTS-1:0]    ctrl_p6_o,
    output logic [NUM_PORTS-1:0]    ctrl_p7_o,
    output logic [NUM_PORTS-1:0]    ctrl_p9_o
);
    localparam int                  C_HOLD_W    = $clog2(KEY_HOLD + 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LOAD = C_HOLD_W'(KEY_HOLD);
    localparam logic [C_HOLD_W-1:0] C_HOLD_ONE  = C_HOLD_W'(1);
    localparam logic [3:0]          C_KEY_NONE  = 4'b1111;
    // Nibble k is the code for priority index k (0-9 digits, *, #, purple, blue)
    localparam logic [55:0] C_KEY_CODES = {4'b0010, 4'b0100, 4'b0101, 4'b1010,
                                           4'b1011, 4'b1000, 4'b1100, 4'b0111,
                                           4'b1001, 4'b0001, 4'b0110, 4'b1101,
                                           4'b1110, 4'b0011};

    generate
        for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            logic [19:0]         w_joy;
            logic [13:0]         w_keys;
            logic [3:0]          w_raw;
            logic [3:0]          w_ctl_key;
            logic [3:0]          w_ctl_joy;
            logic [3:0]          r_held;
            logic [C_HOLD_W-1:0] r_hold_cnt;
            logic [3:0]          r_dir;
            logic                r_p6;

            assign w_joy  = joy_i[20*gp +: 20];
            assign w_keys = {w_joy[19:18], w_joy[7:6], w_joy[17:8]};

            // Scan lowest priority first so the highest-priority key wins
            always_comb begin
                w_raw = C_KEY_NONE;
                for (int k = 13; k >= 0; k--) begin
                    if (w_keys[k]) w_raw = C_KEY_CODES[4*k +: 4];
                end
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_held     <= C_KEY_NONE;
                    r_hold_cnt <= '0;
                end else if (ce_i) begin
                    if (w_raw != C_KEY_NONE && r_hold_cnt == '0) begin
                        r_held     <= w_raw;
                        r_hold_cnt <= C_HOLD_LOAD;
                    end else if (w_raw != C_KEY_NONE && w_raw == r_held) begin
                        r_hold_cnt <= C_HOLD_LOAD;
                    end else if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - C_HOLD_ONE;
                        if (r_hold_cnt == C_HOLD_ONE && w_raw == C_KEY_NONE) r_held <= C_KEY_NONE;
                    end else if (w_raw == C_KEY_NONE) begin
                        r_held <= C_KEY_NONE;
                    end
                end
            end

            assign w_ctl_key = sel_key_n_i[gp] ? C_KEY_NONE : r_held;
            assign w_ctl_joy = sel_joy_n_i[gp] ? C_KEY_NONE : ~w_joy[3:0];

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_dir <= 4'b1111;
                    r_p6  <= 1'b1;
                end else begin
                    r_dir <= w_ctl_key & w_ctl_joy;
                    r_p6  <= (sel_key_n_i[gp] | ~w_joy[5]) & (sel_joy_n_i[gp] | ~w_joy[4]);
                end
            end

            assign ctrl_dir_o[4*gp +: 4] = r_dir;
            assign ctrl_p6_o[gp]         = r_p6;

`ifdef CV_SPINNER_EN
            localparam int                        C_PRE_W    = $clog2(SPIN_DIV);
            localparam logic [C_PRE_W-1:0]        C_PRE_LAST = C_PRE_W'(SPIN_DIV - 1);
            localparam logic [C_PRE_W-1:0]        C_PRE_ONE  = C_PRE_W'(1);
            localparam logic signed [SPIN_W+1:0]  C_ACC_MAX  = (SPIN_W+2)'((1 << (SPIN_W - 1)) - 1);
            localparam logic signed [SPIN_W+1:0]  C_ACC_MIN  = -C_ACC_MAX;
            localparam logic signed [SPIN_W+1:0]  C_SUM_ONE  = (SPIN_W+2)'(1);

            logic [C_PRE_W-1:0]       r_pre;
            logic signed [SPIN_W-1:0] r_acc;
            logic [1:0]               r_phase;
            logic                     r_p7;
            logic                     r_p9;
            logic signed [7:0]        w_delta;
            logic                     w_step;
            logic signed [SPIN_W+1:0] w_sum;
            logic signed [SPIN_W-1:0] w_acc_next;
            logic [1:0]               w_phase_next;

            assign w_delta = spin_delta_i[8*gp +: 8];
            assign w_step  = ce_i && (r_pre == C_PRE_LAST) && (r_acc != '0);

            // Delta and step combine before a single saturation
            always_comb begin
                w_sum        = (SPIN_W+2)'(r_acc);
                w_phase_next = r_phase;
                if (spin_stb_i[gp]) w_sum = w_sum + (SPIN_W+2)'(w_delta);
                if (w_step) begin
                    if (r_acc[SPIN_W-1]) begin
                        w_sum        = w_sum + C_SUM_ONE;
                        w_phase_next = {~r_phase[0], r_phase[1]};
                    end else begin
                        w_sum        = w_sum - C_SUM_ONE;
                        w_phase_next = {r_phase[0], ~r_phase[1]};
                    end
                end
                if (w_sum > C_ACC_MAX)      w_acc_next = C_ACC_MAX[SPIN_W-1:0];
                else if (w_sum < C_ACC_MIN) w_acc_next = C_ACC_MIN[SPIN_W-1:0];
                else                        w_acc_next = w_sum[SPIN_W-1:0];
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_pre   <= '0;
                    r_acc   <= '0;
                    r_phase <= 2'b00;
                    r_p7    <= 1'b1;
                    r_p9    <= 1'b1;
                end else begin
                    if (ce_i) r_pre <= (r_pre == C_PRE_LAST) ? '0 : r_pre + C_PRE_ONE;
                    r_acc   <= w_acc_next;
                    r_phase <= w_phase_next;
                    r_p7    <= ~w_phase_next[0];
                    r_p9    <= ~w_phase_next[1];
                end
            end

            assign ctrl_p7_o[gp] = r_p7;
            assign ctrl_p9_o[gp] = r_p9;
`else
            logic w_spin_unused;

            assign w_spin_unused = ^{spin_delta_i[8*gp +: 8], spin_stb_i[gp]};
            assign ctrl_p7_o[gp] = 1'b1;
            assign ctrl_p9_o[gp] = 1'b1;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cv_ctrl_ports.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : tb_cv_ctrl_ports
//  Self-checking bench for cv_ctrl_ports: directed scenarios plus randomized
//  traffic compared against a behavioural reference model.
//  Rev 1.0 - initial release
// ============================================================================
module tb_cv_ctrl_ports;
    localparam int NP      = 2;
    localparam int KH      = 16;
    localparam int SD      = 64;
    localparam int SW      = 10;
    localparam int ACC_MAX = (1 << (SW - 1)) - 1;

    logic            clk_i     = 1'b0;
    logic            reset_n_i = 1'b1;
    logic            ce_i      = 1'b0;
    logic [20*NP-1:0] joy_i    = '0;
    logic [NP-1:0]   sel_key_n_i = '1;
    logic [NP-1:0]   sel_joy_n_i = '1;
    logic [8*NP-1:0] spin_delta_i = '0;
    logic [NP-1:0]   spin_stb_i = '0;
    logic [4*NP-1:0] ctrl_dir_o;
    logic [NP-1:0]   ctrl_p6_o;
    logic [NP-1:0]   ctrl_p7_o;
    logic [NP-1:0]   ctrl_p9_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    cv_ctrl_ports #(.NUM_PORTS(NP), .KEY_HOLD(KH), .SPIN_DIV(SD), .SPIN_W(SW)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .ce_i         (ce_i),
        .joy_i        (joy_i),
        .sel_key_n_i  (sel_key_n_i),
        .sel_joy_n_i  (sel_joy_n_i),
        .spin_delta_i (spin_delta_i),
        .spin_stb_i   (spin_stb_i),
        .ctrl_dir_o   (ctrl_dir_o),
        .ctrl_p6_o    (ctrl_p6_o),
        .ctrl_p7_o    (ctrl_p7_o),
        .ctrl_p9_o    (ctrl_p9_o)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] key_code(input logic [19:0] w);
        if (w[8])  return 4'b0011;
        if (w[9])  return 4'b1110;
        if (w[10]) return 4'b1101;
        if (w[11]) return 4'b0110;
        if (w[12]) return 4'b0001;
        if (w[13]) return 4'b1001;
        if (w[14]) return 4'b0111;
        if (w[15]) return 4'b1100;
        if (w[16]) return 4'b1000;
        if (w[17]) return 4'b1011;
        if (w[6])  return 4'b1010;
        if (w[7])  return 4'b0101;
        if (w[18]) return 4'b0100;
        if (w[19]) return 4'b0010;
        return 4'b1111;
    endfunction

    function automatic logic [1:0] gray(input int pos);
        case (pos & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    logic [3:0]      m_held [NP];
    int              m_left [NP];
    int              m_acc  [NP];
    int              m_pos  [NP];
    int              m_ticks;
    logic [4*NP-1:0] e_dir;
    logic [NP-1:0]   e_p6, e_p7, e_p9;
    logic            m_step;
    logic [19:0]     m_w;
    logic [3:0]      m_raw, m_kp, m_jp;
    logic [1:0]      m_g;
    int              m_a;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int p = 0; p < NP; p++) begin
                m_held[p] = 4'hF; m_left[p] = 0; m_acc[p] = 0; m_pos[p] = 0;
            end
            m_ticks = 0;
            e_dir = '1; e_p6 = '1; e_p7 = '1; e_p9 = '1;
        end else begin
            m_step = 1'b0;
            if (ce_i) begin
                m_ticks++;
                m_step = (m_ticks % SD) == 0;
            end
            for (int p = 0; p < NP; p++) begin
                m_w   = joy_i[20*p +: 20];
                m_raw = key_code(m_w);
                m_kp  = sel_key_n_i[p] ? 4'hF : m_held[p];
                m_jp  = sel_joy_n_i[p] ? 4'hF : ~m_w[3:0];
                e_dir[4*p +: 4] = m_kp & m_jp;
                e_p6[p] = (sel_key_n_i[p] | ~m_w[5]) & (sel_joy_n_i[p] | ~m_w[4]);
                if (ce_i) begin
                    if (m_raw != 4'hF && m_left[p] == 0) begin
                        m_held[p] = m_raw; m_left[p] = KH;
                    end else if (m_raw != 4'hF && m_raw == m_held[p]) begin
                        m_left[p] = KH;
                    end else if (m_left[p] > 0) begin
                        m_left[p]--;
                        if (m_left[p] == 0 && m_raw == 4'hF) m_held[p] = 4'hF;
                    end else if (m_raw == 4'hF) begin
                        m_held[p] = 4'hF;
                    end
                end
`ifdef CV_SPINNER_EN
                m_a = m_acc[p];
                if (m_step && m_a > 0) begin m_a--; m_pos[p]++; end
                else if (m_step && m_a < 0) begin m_a++; m_pos[p]--; end
                if (spin_stb_i[p]) m_a += int'($signed(spin_delta_i[8*p +: 8]));
                if (m_a > ACC_MAX)  m_a = ACC_MAX;
                if (m_a < -ACC_MAX) m_a = -ACC_MAX;
                m_acc[p] = m_a;
                m_g = gray(m_pos[p]);
                e_p7[p] = ~m_g[0];
                e_p9[p] = ~m_g[1];
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        ce_i = 1'b0; joy_i = '0; sel_key_n_i = '1; sel_joy_n_i = '1;
        spin_delta_i = '0; spin_stb_i = '0;
        cyc(); cyc();
        reset_n_i = 1'b1;
    endtask

    // Counts changes of port0 {p9,p7}; records first codes and edge gaps
    task automatic watch_spin(input int cycles, output int n, output logic [7:0] seq,
                              output int gap01, output int gap12);
        logic [1:0] prev, cur;
        int t[4];
        n = 0; seq = '0; gap01 = -1; gap12 = -1;
        prev = {ctrl_p9_o[0], ctrl_p7_o[0]};
        for (int c = 0; c < cycles; c++) begin
            cyc();
            cur = {ctrl_p9_o[0], ctrl_p7_o[0]};
            if (cur != prev) begin
                if (n < 4) begin seq[2*n +: 2] = cur; t[n] = c; end
                n++;
            end
            prev = cur;
        end
        if (n >= 2) gap01 = t[1] - t[0];
        if (n >= 3) gap12 = t[2] - t[1];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset_n_i = 1'b0;
        ce_i = 1'b0; joy_i = '0; sel_key_n_i = '0; sel_joy_n_i = '0;
        spin_delta_i = '0; spin_stb_i = '0;
        #2;
        n_checks++; if (ctrl_dir_o !== 8'hFF) $display("FAIL rst_dir got %h exp ff", ctrl_dir_o); else n_pass++;
        n_checks++; if (ctrl_p6_o !== 2'b11) $display("FAIL rst_p6 got %b exp 11", ctrl_p6_o); else n_pass++;
        n_checks++; if ({ctrl_p9_o, ctrl_p7_o} !== 4'hF) $display("FAIL rst_spin got %b exp 1111", {ctrl_p9_o, ctrl_p7_o}); else n_pass++;
        cyc(); cyc();
        reset_n_i = 1'b1;
        ce_i = 1'b1;
        repeat (3) cyc();
        n_checks++; if (ctrl_dir_o !== 8'hFF) $display("FAIL idle_dir got %h exp ff", ctrl_dir_o); else n_pass++;
        n_checks++; if ({ctrl_p6_o, ctrl_p9_o, ctrl_p7_o} !== 6'h3F) $display("FAIL idle_lines got %b exp 111111", {ctrl_p6_o, ctrl_p9_o, ctrl_p7_o}); else n_pass++;
    endtask

    task automatic test_key_hold();
        do_reset();
        sel_key_n_i = 2'b10; ce_i = 1'b1;
        joy_i[19:0] = 20'h02000;
        cyc();
        joy_i[19:0] = '0;
        cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b1001) $display("FAIL key5_first got %b exp 1001", ctrl_dir_o[3:0]); else n_pass++;
        n_checks++; if (ctrl_dir_o[7:4] !== 4'b1111) $display("FAIL key5_port1 got %b exp 1111", ctrl_dir_o[7:4]); else n_pass++;
        repeat (KH - 1) cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b1001) $display("FAIL key5_last got %b exp 1001", ctrl_dir_o[3:0]); else n_pass++;
        cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b1111) $display("FAIL key5_expire got %b exp 1111", ctrl_dir_o[3:0]); else n_pass++;
    endtask

    task automatic test_key_priority();
        do_reset();
        sel_key_n_i = 2'b10; ce_i = 1'b1;
        joy_i[19:0] = 20'h20100;
        cyc();
        joy_i[19:0] = 20'h00800;
        cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b0011) $display("FAIL prio_0_9 got %b exp 0011", ctrl_dir_o[3:0]); else n_pass++;
        repeat (KH - 1) cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b0011) $display("FAIL ignore_3 got %b exp 0011", ctrl_dir_o[3:0]); else n_pass++;
        cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b0011) $display("FAIL ignore_3_end got %b exp 0011", ctrl_dir_o[3:0]); else n_pass++;
        cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b0110) $display("FAIL take_3 got %b exp 0110", ctrl_dir_o[3:0]); else n_pass++;
    endtask

    task automatic test_joy_merge();
        do_reset();
        ce_i = 1'b1; sel_joy_n_i = 2'b10;
        joy_i[19:0] = 20'h00019;
        cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b0110) $display("FAIL joy_ur got %b exp 0110", ctrl_dir_o[3:0]); else n_pass++;
        n_checks++; if (ctrl_p6_o[0] !== 1'b0) $display("FAIL joy_fire1 got %b exp 0", ctrl_p6_o[0]); else n_pass++;
        sel_key_n_i = 2'b10;
        joy_i[19:0] = 20'h00099;
        cyc(); cyc();
        n_checks++; if (ctrl_dir_o[3:0] !== 4'b0100) $display("FAIL merge_hash got %b exp 0100", ctrl_dir_o[3:0]); else n_pass++;
        sel_joy_n_i = 2'b11;
        joy_i[19:0] = 20'h00020;
        cyc();
        n_checks++; if (ctrl_p6_o[0] !== 1'b0) $display("FAIL key_fire2 got %b exp 0", ctrl_p6_o[0]); else n_pass++;
        joy_i[19:0] = 20'h00010;
        cyc();
        n_checks++; if (ctrl_p6_o[0] !== 1'b1) $display("FAIL fire1_unsel got %b exp 1", ctrl_p6_o[0]); else n_pass++;
    endtask

`ifdef CV_SPINNER_EN
    task automatic test_spinner();
        int n, g01, g12, waited;
        logic [7:0] seq;
        do_reset();
        ce_i = 1'b1;
        spin_delta_i[7:0] = 8'd3; spin_stb_i = 2'b01;
        cyc();
        spin_stb_i = '0;
        watch_spin(5 * SD, n, seq, g01, g12);
        n_checks++; if (n !== 3) $display("FAIL fwd_steps got %0d exp 3", n); else n_pass++;
        n_checks++; if (seq[5:0] !== 6'b01_00_10) $display("FAIL fwd_seq got %b exp 010010", seq[5:0]); else n_pass++;
        n_checks++; if (g01 !== SD || g12 !== SD) $display("FAIL fwd_gap got %0d,%0d exp %0d", g01, g12, SD); else n_pass++;
        spin_delta_i[7:0] = 8'hFE; spin_stb_i = 2'b01;
        cyc();
        spin_stb_i = '0;
        watch_spin(4 * SD, n, seq, g01, g12);
        n_checks++; if (n !== 2) $display("FAIL rev_steps got %0d exp 2", n); else n_pass++;
        n_checks++; if (seq[3:0] !== 4'b10_00) $display("FAIL rev_seq got %b exp 1000", seq[3:0]); else n_pass++;

        // Saturation: 8 x +127 clamps at ACC_MAX, 4 x -127 then leaves 3 steps
        do_reset();
        spin_stb_i = 2'b01;
        spin_delta_i[7:0] = 8'd127;
        repeat (8) cyc();
        spin_delta_i[7:0] = 8'h81;
        repeat (4) cyc();
        spin_stb_i = '0; ce_i = 1'b1;
        watch_spin(6 * SD, n, seq, g01, g12);
        n_checks++; if (n !== ACC_MAX - 4 * 127) $display("FAIL sat_steps got %0d exp %0d", n, ACC_MAX - 4 * 127); else n_pass++;

        // Strobe coinciding with a step leaves the accumulator unchanged
        do_reset();
        spin_delta_i[7:0] = 8'd2; spin_stb_i = 2'b01;
        cyc();
        spin_stb_i = '0; ce_i = 1'b1;
        waited = 0;
        while (((m_ticks + 1) % SD) != 0 && waited < 2 * SD) begin cyc(); waited++; end
        n_checks++; if (waited >= 2 * SD) $display("FAIL coin_wait got %0d exp <%0d", waited, 2 * SD); else n_pass++;
        spin_delta_i[7:0] = 8'd1; spin_stb_i = 2'b01;
        fork
            begin cyc(); spin_stb_i = '0; end
            watch_spin(4 * SD, n, seq, g01, g12);
        join
        n_checks++; if (n !== 3) $display("FAIL coin_steps got %0d exp 3", n); else n_pass++;
    endtask
`else
    task automatic test_spinner();
        do_reset();
        ce_i = 1'b1;
        for (int c = 0; c < 3 * SD; c++) begin
            spin_stb_i   = NP'($urandom_range(0, 3));
            spin_delta_i = 16'($urandom);
            cyc();
            n_checks++;
            if ({ctrl_p9_o, ctrl_p7_o} !== 4'hF) $display("FAIL spin_off got %b exp 1111", {ctrl_p9_o, ctrl_p7_o});
            else n_pass++;
        end
        spin_stb_i = '0;
    endtask
`endif

    task automatic test_random();
        logic [13:0] kp [NP];
        do_reset();
        for (int p = 0; p < NP; p++) kp[p] = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 9) < 3) begin
                    kp[p] = '0;
                    if ($urandom_range(0, 2) == 0) kp[p][$urandom_range(0, 13)] = 1'b1;
                    if ($urandom_range(0, 5) == 0) kp[p][$urandom_range(0, 13)] = 1'b1;
                end
                joy_i[20*p +: 20] = {kp[p], 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
                spin_delta_i[8*p +: 8] = 8'($urandom_range(0, 255));
            end
            sel_key_n_i = NP'($urandom_range(0, 3));
            sel_joy_n_i = NP'($urandom_range(0, 3));
            ce_i        = ($urandom_range(0, 2) != 0);
            spin_stb_i  = NP'(($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0);
            cyc();
            n_checks++;
            if ({ctrl_dir_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o} !== {e_dir, e_p6, e_p7, e_p9})
                $display("FAIL rand_c%0d got %h/%b/%b/%b exp %h/%b/%b/%b", c,
                         ctrl_dir_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o, e_dir, e_p6, e_p7, e_p9);
            else n_pass++;
            if (c == 2000) begin
                #2 reset_n_i = 1'b0;
                #1;
                n_checks++;
                if ({ctrl_dir_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o} !== 14'h3FFF)
                    $display("FAIL async_rst got %h/%b/%b/%b exp all ones", ctrl_dir_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o);
                else n_pass++;
                cyc();
                reset_n_i = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_key_hold();
        test_key_priority();
        test_joy_merge();
        test_spinner();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
